// File: rtl/addr_byte_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_byte_serializer_if
// Description : Command side (start/addr_in) and byte-stream side
//               (valid/ready) signals of the address byte serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface addr_byte_serializer_if #(
    parameter int ADDR_W = 18
) ();
    logic              start;
    logic [ADDR_W-1:0] addr_in;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic [1:0]        byte_idx;
    logic              busy;
    logic              done;

    // Serializer side.
    modport slave (
        input  start,
        input  addr_in,
        input  byte_ready,
        output byte_out,
        output byte_valid,
        output byte_idx,
        output busy,
        output done
    );

    // Requester / sink side.
    modport master (
        output start,
        output addr_in,
        output byte_ready,
        input  byte_out,
        input  byte_valid,
        input  byte_idx,
        input  busy,
        input  done
    );
endinterface : addr_byte_serializer_if
`default_nettype wire

// File: rtl/addr_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : addr_byte_serializer
// Description : Emits an address word as bytes, most significant first, over
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_byte_serializer #(
    parameter int ADDR_W = 18,
    parameter int BYTE_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    addr_byte_serializer_if.slave bus
);

    localparam int NBYTES = (ADDR_W + BYTE_W - 1) / BYTE_W;
    localparam int SR_W   = NBYTES * BYTE_W;
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    if ((ADDR_W < 9) || (ADDR_W > 32)) begin : g_bad_addr_w
        $error("addr_byte_serializer: ADDR_W must be within 9..32");
    end
    if (BYTE_W != 8) begin : g_bad_byte_w
        $error("addr_byte_serializer: BYTE_W must be 8");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   addr_ext_d;
    logic [SR_W-1:0]   sr_shifted_d;
    logic [1:0]        cnt_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    // Zero-extend the address so the first byte carries the unused top bits as 0.
    if (SR_W > ADDR_W) begin : g_zero_ext
        assign addr_ext_d = {{(SR_W - ADDR_W){1'b0}}, bus.addr_in};
    end else begin : g_no_ext
        assign addr_ext_d = bus.addr_in;
    end

    assign sr_shifted_d = {sr_q[SR_W-BYTE_W-1:0], {BYTE_W{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        sr_q    <= addr_ext_d;
                        cnt_q   <= 2'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Everything holds under backpressure; only a handshake advances.
                    if (bus.byte_ready) begin
                        sr_q <= sr_shifted_d;
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= 2'd0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.byte_out   = sr_q[SR_W-1 -: BYTE_W];
    assign bus.byte_idx   = cnt_q;
    assign bus.byte_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule : addr_byte_serializer
`default_nettype wire

// File: tb/tb_addr_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_byte_serializer
// Description : Directed, table-driven bench for addr_byte_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_byte_serializer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [23:0] recon;

    addr_byte_serializer_if #(.ADDR_W(18)) bus ();

    addr_byte_serializer #(.ADDR_W(18), .BYTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [17:0] a);
        bus.addr_in = a;
        bus.start   = 1'b1;
        recon       = '0;
        step();
        bus.start   = 1'b0;
        check("accept_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("accept_busy",  {31'd0, bus.busy},       32'd1);
    endtask

    // One handshake: offer ready, verify the byte on offer, then clock it in.
    task automatic expect_byte(input logic [7:0] b, input logic [1:0] idx);
        bus.byte_ready = 1'b1;
        check("byte_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("byte_out",   {24'd0, bus.byte_out},   {24'd0, b});
        check("byte_idx",   {30'd0, bus.byte_idx},   {30'd0, idx});
        check("busy_send",  {31'd0, bus.busy},       32'd1);
        check("no_done",    {31'd0, bus.done},       32'd0);
        recon = {recon[15:0], bus.byte_out};
        step();
    endtask

    // Checks the done cycle; leaves time at the done cycle.
    task automatic check_done(input logic [17:0] a);
        check("done_pulse", {31'd0, bus.done},       32'd1);
        check("done_busy",  {31'd0, bus.busy},       32'd0);
        check("done_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("round_trip", {8'd0, recon},           {14'd0, a});
    endtask

    task automatic after_done();
        step();
        check("done_once", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{addr: 18'h2ABCD, b0: 8'h02, b1: 8'hAB, b2: 8'hCD};
        vecs[1] = '{addr: 18'h3FFFF, b0: 8'h03, b1: 8'hFF, b2: 8'hFF};
        vecs[2] = '{addr: 18'h00000, b0: 8'h00, b1: 8'h00, b2: 8'h00};
        vecs[3] = '{addr: 18'h15555, b0: 8'h01, b1: 8'h55, b2: 8'h55};
        vecs[4] = '{addr: 18'h10203, b0: 8'h01, b1: 8'h02, b2: 8'h03};

        n_checks       = 0;
        n_fail         = 0;
        recon          = '0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.addr_in    = '0;
        bus.byte_ready = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},       32'd0);
        check("rst_done",  {31'd0, bus.done},       32'd0);
        check("rst_byte",  {24'd0, bus.byte_out},   32'd0);
        check("rst_idx",   {30'd0, bus.byte_idx},   32'd0);
        rst = 1'b0;
        step();

        // Basic sends and round trips with the sink always ready.
        for (int i = 0; i < 5; i++) begin
            start_word(vecs[i].addr);
            expect_byte(vecs[i].b0, 2'd0);
            expect_byte(vecs[i].b1, 2'd1);
            expect_byte(vecs[i].b2, 2'd2);
            check_done(vecs[i].addr);
            after_done();
            check("idle_valid", {31'd0, bus.byte_valid}, 32'd0);
        end

        // Backpressure on byte 1 for three cycles.
        start_word(18'h3FFFF);
        expect_byte(8'h03, 2'd0);
        bus.byte_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid", {31'd0, bus.byte_valid}, 32'd1);
            check("bp_byte",  {24'd0, bus.byte_out},   32'hFF);
            check("bp_idx",   {30'd0, bus.byte_idx},   32'd1);
            check("bp_done",  {31'd0, bus.done},       32'd0);
        end
        expect_byte(8'hFF, 2'd1);
        expect_byte(8'hFF, 2'd2);
        check_done(18'h3FFFF);
        after_done();

        // A start pulse and address change during SEND are ignored.
        start_word(18'h00001);
        expect_byte(8'h00, 2'd0);
        bus.start   = 1'b1;
        bus.addr_in = 18'h12345;
        expect_byte(8'h00, 2'd1);
        bus.start   = 1'b0;
        expect_byte(8'h01, 2'd2);
        check_done(18'h00001);
        after_done();
        check("ignore_idle1", {31'd0, bus.byte_valid}, 32'd0);
        step();
        check("ignore_idle2", {31'd0, bus.byte_valid}, 32'd0);

        // Back-to-back: start held high, next word presented in the done cycle.
        bus.addr_in = 18'h10203;
        bus.start   = 1'b1;
        recon       = '0;
        step();
        expect_byte(8'h01, 2'd0);
        expect_byte(8'h02, 2'd1);
        expect_byte(8'h03, 2'd2);
        check_done(18'h10203);
        bus.addr_in = 18'h00AA0;
        recon       = '0;
        step();
        bus.start = 1'b0;
        check("b2b_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("b2b_nodone", {31'd0, bus.done},      32'd0);
        expect_byte(8'h00, 2'd0);
        expect_byte(8'h0A, 2'd1);
        expect_byte(8'hA0, 2'd2);
        check_done(18'h00AA0);
        after_done();

        // Asynchronous reset mid-transfer, then a fresh word.
        start_word(18'h2ABCD);
        expect_byte(8'h02, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("arst_busy",  {31'd0, bus.busy},       32'd0);
        check("arst_done",  {31'd0, bus.done},       32'd0);
        check("arst_idx",   {30'd0, bus.byte_idx},   32'd0);
        check("arst_byte",  {24'd0, bus.byte_out},   32'd0);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_idle", {31'd0, bus.byte_valid}, 32'd0);
        check("post_rst_done", {31'd0, bus.done},       32'd0);
        start_word(18'h00000);
        expect_byte(8'h00, 2'd0);
        expect_byte(8'h00, 2'd1);
        expect_byte(8'h00, 2'd2);
        check_done(18'h00000);
        after_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_addr_byte_serializer
`default_nettype wire
